bullet_pool_arbiter: RTL and testbench
======================================

BULLET_POOL_ARBITER -- requirements
Module: bullet_pool_arbiter

Interface
REQ-001 SHALL have parameter Y_MAX, default 8'd119, meaning the last y row a bullet occupies before it retires.
REQ-002 SHALL have parameter COOLDOWN, default 4'd8, meaning the number of ticks a requester is blocked after it receives a grant.
REQ-003 SHALL have port movement_handler_clock, input, 1 bit, the movement tick clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is synchronous and active-high, sampled on movement_handler_clock.
REQ-005 SHALL have port fire_req, input, 4 bits, one fire request per enemy, level-sensitive.
REQ-006 SHALL have port enemy_x, input, 32 bits; the x of requester i is on bits [8i+7:8i].
REQ-007 SHALL have port hit, input, 4 bits, one per slot; retires that slot's bullet.
REQ-008 SHALL have port fire_gnt, output, 4 bits; a one-hot, single-tick registered grant.
REQ-009 SHALL have port slot_valid, output, 4 bits, one per bullet slot: slot is active.
REQ-010 SHALL have port slot_x, output, 32 bits; the x of slot s is on bits [8s+7:8s].
REQ-011 SHALL have port slot_y, output, 32 bits; the y of slot s is on bits [8s+7:8s].
REQ-012 SHALL have port pool_full, output, 1 bit; it is high when all slots are valid.

Function
REQ-013 Eligibility: requester i is eligible at a tick when fire_req[i]=1 and cooldown[i]=0.
REQ-014 Grants: at most one grant per tick, and only if at least one slot is free, judged on the slot_valid value before the edge.
REQ-015 Round-robin search: starts at rr_ptr and runs rr_ptr, rr_ptr+1, ... mod 4; the first eligible requester wins.
REQ-016 Slot choice: the winner is placed in the lowest-index free slot.
REQ-017 On a grant to requester i into slot s, at the next edge:
  - fire_gnt[i]=1;
  - slot_valid[s]=1;
  - slot_x[s]=enemy_x[i] as sampled on the granting edge;
  - slot_y[s]=0;
  - cooldown[i]=COOLDOWN;
  - rr_ptr=(i+1) mod 4.
REQ-018 Grant latency: a request sampled at edge n SHALL produce fire_gnt and slot_valid high after edge n, for exactly one tick for fire_gnt.
REQ-019 No grant: fire_gnt=0 and rr_ptr holds; a blocked (cooling) requester never advances rr_ptr.
REQ-020 Cooldown: each nonzero cooldown[i] decrements by 1 per tick and saturates at 0.
REQ-021 Bullet advance: each valid slot not retiring increments slot_y by 1 per tick; slot_x holds.
REQ-022 Retire: a slot retires (slot_valid=0 next tick) when it is valid and either hit[s]=1 or slot_y[s]==Y_MAX; hit takes priority.
REQ-023 hit[s] on an invalid slot SHALL be ignored.
REQ-024 A slot retiring at a tick SHALL NOT be reallocated on that same edge; it becomes allocatable the following tick.
REQ-025 Retired slots hold their last slot_x and slot_y values; consumers qualify them with slot_valid.
REQ-026 pool_full SHALL be combinational &slot_valid.
REQ-027 All requests pending while pool_full=1 are held off with no grant and no pointer change.
REQ-028 Simultaneous retire and grant on the same edge are independent: a retire of slot a and a grant into a free slot b both occur.

Reset
REQ-029 Reset clears the following to 0 at the next edge: fire_gnt, slot_valid, slot_x, slot_y, all cooldown counters, and rr_ptr.
REQ-030 Reset asserted mid-flight SHALL override grants, retires, and increments at that edge; in-flight bullets are discarded.
REQ-031 Reset holds all state at reset values for as long as it stays asserted.

Verification
REQ-032 Simple fire: reset, then fire_req=4'b0001 with enemy_x[7:0]=8'd40 for 1 tick -> next tick fire_gnt=4'b0001, slot_valid=4'b0001, slot_x[7:0]=40, slot_y[7:0]=0; slot_y then reaches 5 after 5 more ticks.
REQ-033 All four requesting: fire_req=4'b1111 held with rr_ptr=0 and COOLDOWN=8 -> grants 0,1,2,3 on consecutive ticks into slots 0..3; pool_full=1; no further grant while full.
REQ-034 Retire by range: a bullet is fired and left alone -> slot_valid drops on the tick after slot_y==119; a waiting request is granted into that slot one tick later.
REQ-035 Retire by hit: hit[2]=1 on valid slot 2 together with a pending request -> slot 2 invalid next tick; the request gets a free slot other than 2 on that edge, or slot 2 one tick later if the pool was full.
REQ-036 Cooldown: requester 1 is granted and holds fire_req -> no grant to 1 for the next 8 ticks; granted again on tick 9; other requesters are served in between.
REQ-037 Reset mid-flight: three slots active, then reset for 1 tick -> all outputs 0 next tick, and rr_ptr=0 confirmed by requester 0 winning a 4'b1111 request.

Source files
------------

// File: rtl/bullet_pool_arbiter_if.sv
// Bus bundle between the enemy fire logic and the bullet pool arbiter.
// The master side drives requests, enemy positions and hits; the slave side reports grants and slots.
interface bullet_pool_arbiter_if;
    logic [3:0]  fire_req;
    logic [31:0] enemy_x;
    logic [3:0]  hit;
    logic [3:0]  fire_gnt;
    logic [3:0]  slot_valid;
    logic [31:0] slot_x;
    logic [31:0] slot_y;
    logic        pool_full;

    modport master (
        output fire_req, enemy_x, hit,
        input  fire_gnt, slot_valid, slot_x, slot_y, pool_full
    );

    modport slave (
        input  fire_req, enemy_x, hit,
        output fire_gnt, slot_valid, slot_x, slot_y, pool_full
    );
endinterface

// File: rtl/bullet_pool_arbiter.sv
// Round-robin arbiter that hands four enemy fire requests into a pool of four bullet slots.
// Each slot's bullet moves down one row per tick and retires on a hit or at the last row.
module bullet_pool_arbiter #(
    parameter logic [7:0] Y_MAX    = 8'd119,
    parameter logic [3:0] COOLDOWN = 4'd8
) (
    input  logic                 movement_handler_clock,
    input  logic                 reset,
    bullet_pool_arbiter_if.slave bus
);

    logic [3:0]       fire_gnt_q, fire_gnt_d;
    logic [3:0]       slot_valid_q, slot_valid_d;
    logic [3:0][7:0]  slot_x_q, slot_x_d;
    logic [3:0][7:0]  slot_y_q, slot_y_d;
    logic [3:0][3:0]  cooldown_q, cooldown_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;

    logic [3:0] eligible;
    logic [1:0] idx;
    logic [1:0] winner;
    logic [1:0] slot_sel;
    logic       found;
    logic       grant;

    // Arbitration looks only at pre-edge slot_valid, so a retiring slot is not reusable until the next tick.
    always_comb begin
        eligible = '0;
        idx      = '0;
        winner   = rr_ptr_q;
        found    = 1'b0;
        slot_sel = '0;
        for (int i = 0; i < 4; i++) begin
            eligible[i] = bus.fire_req[i] && (cooldown_q[i] == 4'd0);
        end
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr_q + k[1:0];
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        for (int s = 3; s >= 0; s--) begin
            if (!slot_valid_q[s]) begin
                slot_sel = s[1:0];
            end
        end
        grant = found && !(&slot_valid_q);
    end

    always_comb begin
        fire_gnt_d   = '0;
        rr_ptr_d     = rr_ptr_q;
        slot_valid_d = slot_valid_q;
        slot_x_d     = slot_x_q;
        slot_y_d     = slot_y_q;
        cooldown_d   = cooldown_q;

        for (int i = 0; i < 4; i++) begin
            cooldown_d[i] = (cooldown_q[i] != 4'd0) ? cooldown_q[i] - 4'd1 : 4'd0;
        end

        for (int s = 0; s < 4; s++) begin
            if (slot_valid_q[s]) begin
                if (bus.hit[s] || (slot_y_q[s] == Y_MAX)) begin
                    slot_valid_d[s] = 1'b0;
                end else begin
                    slot_y_d[s] = slot_y_q[s] + 8'd1;
                end
            end
        end

        // The chosen slot was free before the edge, so it never collides with a retire or advance.
        if (grant) begin
            fire_gnt_d[winner]     = 1'b1;
            cooldown_d[winner]     = COOLDOWN;
            rr_ptr_d               = winner + 2'd1;
            slot_valid_d[slot_sel] = 1'b1;
            slot_x_d[slot_sel]     = bus.enemy_x[{winner, 3'b000} +: 8];
            slot_y_d[slot_sel]     = 8'd0;
        end
    end

    always_ff @(posedge movement_handler_clock) begin
        if (reset) begin
            fire_gnt_q   <= '0;
            slot_valid_q <= '0;
            slot_x_q     <= '0;
            slot_y_q     <= '0;
            cooldown_q   <= '0;
            rr_ptr_q     <= '0;
        end else begin
            fire_gnt_q   <= fire_gnt_d;
            slot_valid_q <= slot_valid_d;
            slot_x_q     <= slot_x_d;
            slot_y_q     <= slot_y_d;
            cooldown_q   <= cooldown_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign bus.fire_gnt   = fire_gnt_q;
    assign bus.slot_valid = slot_valid_q;
    assign bus.slot_x     = slot_x_q;
    assign bus.slot_y     = slot_y_q;
    assign bus.pool_full  = &slot_valid_q;

endmodule

// File: tb/tb_bullet_pool_arbiter.sv
// Directed testbench for bullet_pool_arbiter: each task drives one scenario and checks
// hand-computed grant, slot and pool values one tick at a time.
module tb_bullet_pool_arbiter;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    bullet_pool_arbiter_if bus ();

    bullet_pool_arbiter dut (
        .movement_handler_clock (clk),
        .reset                  (reset),
        .bus                    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one tick; inputs and observations happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.fire_req = '0;
        bus.hit      = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.enemy_x  = 32'h11223344;
        bus.hit      = '0;
        bus.fire_req = 4'b1111;
        reset        = 1'b1;
        tick();
        tick();
        tests_run++;
        if (bus.fire_gnt !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_gnt: got %b expected %b", bus.fire_gnt, 4'b0000);
        end
        tests_run++;
        if (bus.slot_valid !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid: got %b expected %b", bus.slot_valid, 4'b0000);
        end
        tests_run++;
        if ((bus.slot_x !== 32'h0) || (bus.slot_y !== 32'h0)) begin
            tests_failed++;
            $display("[TB] FAIL reset_xy: got x=%h y=%h expected 0", bus.slot_x, bus.slot_y);
        end
        tests_run++;
        if (bus.pool_full !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_full: got %b expected 0", bus.pool_full);
        end
        reset        = 1'b0;
        bus.fire_req = '0;
    endtask

    task automatic test_simple_fire();
        do_reset();
        bus.enemy_x  = 32'h0000_0028;
        bus.fire_req = 4'b0001;
        tick();
        bus.fire_req = 4'b0000;
        tests_run++;
        if (bus.fire_gnt !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL simple_gnt: got %b expected %b", bus.fire_gnt, 4'b0001);
        end
        tests_run++;
        if (bus.slot_valid !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL simple_valid: got %b expected %b", bus.slot_valid, 4'b0001);
        end
        tests_run++;
        if ((bus.slot_x[7:0] !== 8'd40) || (bus.slot_y[7:0] !== 8'd0)) begin
            tests_failed++;
            $display("[TB] FAIL simple_xy: got x=%0d y=%0d expected x=40 y=0", bus.slot_x[7:0], bus.slot_y[7:0]);
        end
        repeat (5) tick();
        tests_run++;
        if ((bus.slot_y[7:0] !== 8'd5) || (bus.fire_gnt !== 4'b0000)) begin
            tests_failed++;
            $display("[TB] FAIL simple_advance: got y=%0d gnt=%b expected y=5 gnt=0000", bus.slot_y[7:0], bus.fire_gnt);
        end
    endtask

    task automatic test_all_four();
        logic [3:0] exp_gnt;
        logic [3:0] exp_valid;
        do_reset();
        bus.enemy_x  = {8'd70, 8'd60, 8'd50, 8'd40};
        bus.fire_req = 4'b1111;
        exp_valid    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_gnt   = 4'b0001 << i;
            exp_valid = exp_valid | exp_gnt;
            tests_run++;
            if ((bus.fire_gnt !== exp_gnt) || (bus.slot_valid !== exp_valid)) begin
                tests_failed++;
                $display("[TB] FAIL all4_grant%0d: got gnt=%b valid=%b expected gnt=%b valid=%b",
                         i, bus.fire_gnt, bus.slot_valid, exp_gnt, exp_valid);
            end
        end
        tests_run++;
        if ((bus.pool_full !== 1'b1) || (bus.slot_x !== 32'h463C3228) || (bus.slot_y !== 32'h00010203)) begin
            tests_failed++;
            $display("[TB] FAIL all4_pool: got full=%b x=%h y=%h expected full=1 x=463c3228 y=00010203",
                     bus.pool_full, bus.slot_x, bus.slot_y);
        end
        // Hold long enough for every cooldown to expire; the full pool alone must block grants.
        for (int t = 0; t < 12; t++) begin
            tick();
            tests_run++;
            if ((bus.fire_gnt !== 4'b0000) || (bus.pool_full !== 1'b1)) begin
                tests_failed++;
                $display("[TB] FAIL all4_hold%0d: got gnt=%b full=%b expected gnt=0000 full=1",
                         t, bus.fire_gnt, bus.pool_full);
            end
        end
        bus.fire_req = '0;
    endtask

    task automatic test_hit_full();
        // Pool is full from test_all_four, rr_ptr=0, all cooldowns expired.
        bus.enemy_x  = {8'd70, 8'd60, 8'd99, 8'd40};
        bus.fire_req = 4'b0010;
        bus.hit      = 4'b0100;
        tick();
        bus.hit = 4'b0000;
        tests_run++;
        if ((bus.slot_valid !== 4'b1011) || (bus.fire_gnt !== 4'b0000)) begin
            tests_failed++;
            $display("[TB] FAIL hitfull_retire: got valid=%b gnt=%b expected valid=1011 gnt=0000",
                     bus.slot_valid, bus.fire_gnt);
        end
        tick();
        bus.fire_req = '0;
        tests_run++;
        if ((bus.slot_valid !== 4'b1111) || (bus.fire_gnt !== 4'b0010) ||
            (bus.slot_x[23:16] !== 8'd99) || (bus.slot_y[23:16] !== 8'd0)) begin
            tests_failed++;
            $display("[TB] FAIL hitfull_regrant: got valid=%b gnt=%b x2=%0d y2=%0d expected 1111 0010 99 0",
                     bus.slot_valid, bus.fire_gnt, bus.slot_x[23:16], bus.slot_y[23:16]);
        end
    endtask

    task automatic test_hit_with_free();
        do_reset();
        bus.enemy_x  = {8'd0, 8'd30, 8'd20, 8'd10};
        bus.fire_req = 4'b0001;
        tick();
        bus.fire_req = 4'b0010;
        tick();
        bus.fire_req = 4'b0100;
        bus.hit      = 4'b0001;
        tick();
        bus.fire_req = 4'b0000;
        bus.hit      = 4'b0000;
        tests_run++;
        if ((bus.slot_valid !== 4'b0110) || (bus.fire_gnt !== 4'b0100) || (bus.slot_x[23:16] !== 8'd30)) begin
            tests_failed++;
            $display("[TB] FAIL hitfree_same_edge: got valid=%b gnt=%b x2=%0d expected 0110 0100 30",
                     bus.slot_valid, bus.fire_gnt, bus.slot_x[23:16]);
        end
        tests_run++;
        if (bus.slot_x[7:0] !== 8'd10) begin
            tests_failed++;
            $display("[TB] FAIL hitfree_hold_x: got %0d expected 10", bus.slot_x[7:0]);
        end
        bus.hit = 4'b1001;
        tick();
        bus.hit = 4'b0000;
        tests_run++;
        if (bus.slot_valid !== 4'b0110) begin
            tests_failed++;
            $display("[TB] FAIL hit_invalid_ignored: got %b expected %b", bus.slot_valid, 4'b0110);
        end
    endtask

    task automatic test_range_retire();
        do_reset();
        bus.enemy_x  = {8'd70, 8'd60, 8'd50, 8'd40};
        bus.fire_req = 4'b1111;
        repeat (4) tick();
        repeat (116) tick();
        tests_run++;
        if ((bus.slot_valid !== 4'b1111) || (bus.slot_y[7:0] !== 8'd119) || (bus.slot_y[15:8] !== 8'd118)) begin
            tests_failed++;
            $display("[TB] FAIL range_at_max: got valid=%b y0=%0d y1=%0d expected 1111 119 118",
                     bus.slot_valid, bus.slot_y[7:0], bus.slot_y[15:8]);
        end
        tick();
        tests_run++;
        if ((bus.slot_valid !== 4'b1110) || (bus.fire_gnt !== 4'b0000)) begin
            tests_failed++;
            $display("[TB] FAIL range_retire: got valid=%b gnt=%b expected 1110 0000", bus.slot_valid, bus.fire_gnt);
        end
        tick();
        tests_run++;
        if ((bus.slot_valid !== 4'b1101) || (bus.fire_gnt !== 4'b0001) ||
            (bus.slot_y[7:0] !== 8'd0) || (bus.slot_x[7:0] !== 8'd40)) begin
            tests_failed++;
            $display("[TB] FAIL range_regrant: got valid=%b gnt=%b y0=%0d x0=%0d expected 1101 0001 0 40",
                     bus.slot_valid, bus.fire_gnt, bus.slot_y[7:0], bus.slot_x[7:0]);
        end
        bus.fire_req = '0;
    endtask

    task automatic test_cooldown();
        do_reset();
        bus.enemy_x  = 32'h04030201;
        bus.fire_req = 4'b0010;
        tick();
        tests_run++;
        if (bus.fire_gnt !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL cool_first: got %b expected %b", bus.fire_gnt, 4'b0010);
        end
        bus.fire_req = 4'b0011;
        tick();
        tests_run++;
        if (bus.fire_gnt !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL cool_other_served: got %b expected %b", bus.fire_gnt, 4'b0001);
        end
        for (int t = 3; t <= 9; t++) begin
            tick();
            tests_run++;
            if (bus.fire_gnt !== 4'b0000) begin
                tests_failed++;
                $display("[TB] FAIL cool_blocked_t%0d: got %b expected 0000", t, bus.fire_gnt);
            end
        end
        tick();
        tests_run++;
        if ((bus.fire_gnt !== 4'b0010) || (bus.slot_valid !== 4'b0111)) begin
            tests_failed++;
            $display("[TB] FAIL cool_regrant: got gnt=%b valid=%b expected 0010 0111", bus.fire_gnt, bus.slot_valid);
        end
        tick();
        bus.fire_req = '0;
        tests_run++;
        if ((bus.fire_gnt !== 4'b0001) || (bus.pool_full !== 1'b1)) begin
            tests_failed++;
            $display("[TB] FAIL cool_req0_again: got gnt=%b full=%b expected 0001 1", bus.fire_gnt, bus.pool_full);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.enemy_x  = {8'd9, 8'd8, 8'd7, 8'd6};
        bus.fire_req = 4'b0111;
        repeat (3) tick();
        tests_run++;
        if (bus.slot_valid !== 4'b0111) begin
            tests_failed++;
            $display("[TB] FAIL mid_setup: got %b expected %b", bus.slot_valid, 4'b0111);
        end
        bus.fire_req = 4'b1111;
        bus.hit      = 4'b0001;
        reset        = 1'b1;
        tick();
        bus.hit = 4'b0000;
        tests_run++;
        if ((bus.fire_gnt !== 4'b0000) || (bus.slot_valid !== 4'b0000) ||
            (bus.slot_x !== 32'h0) || (bus.slot_y !== 32'h0) || (bus.pool_full !== 1'b0)) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: got gnt=%b valid=%b x=%h y=%h full=%b expected all 0",
                     bus.fire_gnt, bus.slot_valid, bus.slot_x, bus.slot_y, bus.pool_full);
        end
        reset = 1'b0;
        tick();
        bus.fire_req = '0;
        tests_run++;
        if ((bus.fire_gnt !== 4'b0001) || (bus.slot_valid !== 4'b0001) || (bus.slot_x[7:0] !== 8'd6)) begin
            tests_failed++;
            $display("[TB] FAIL mid_rrptr: got gnt=%b valid=%b x0=%0d expected 0001 0001 6",
                     bus.fire_gnt, bus.slot_valid, bus.slot_x[7:0]);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        bus.fire_req = '0;
        bus.enemy_x  = '0;
        bus.hit      = '0;
        #1;
        test_reset();
        test_simple_fire();
        test_all_four();
        test_hit_full();
        test_hit_with_free();
        test_range_retire();
        test_cooldown();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
